// File: rtl/aes_iter_core.sv
// rtl/aes_iter_core.sv - iterative AES encryption core, RPC rounds per clock, round keys streamed in.
// Build option AES_KEY_STALL_EN: beats wait for key_valid; otherwise every RUN cycle consumes a key beat.
module aes_iter_core #(
    parameter int NR  = 10,
    parameter int RPC = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [127:0]         in_data,
    input  logic                 key_valid,
    output logic                 key_ready,
    input  logic [128*RPC-1:0]   key_data,
    input  logic [127:0]         key_fin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [127:0]         out_data
);
    localparam int B  = NR / RPC;
    localparam int CW = (B > 1) ? $clog2(B) : 1;

    if (!((NR == 10 || NR == 12 || NR == 14) && RPC >= 1 && RPC <= NR && (NR % RPC) == 0)) begin : g_bad_cfg
        $error("aes_iter_core: illegal NR/RPC combination");
    end

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte i of the state is bits [127-8i -: 8]; column c holds bytes 4c..4c+3.
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [0:15][7:0] a;
        logic [0:15][7:0] sr;
        logic [0:15][7:0] mc;
        logic [7:0] a0, a1, a2, a3;
        a = s ^ k;
        for (int i = 0; i < 16; i++) a[i] = sbox(a[i]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[4*c+r] = a[4*((c+r)%4)+r];
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c]; a1 = sr[4*c+1]; a2 = sr[4*c+2]; a3 = sr[4*c+3];
            mc[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            mc[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            mc[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            mc[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return last ? sr : mc;
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         st;
    logic [CW-1:0]  cnt;
    logic [127:0]   state_q;
    logic [127:0]   chain_out;
    logic           beat;

`ifdef AES_KEY_STALL_EN
    assign beat = key_valid && key_ready;
`else
    logic unused_key_valid;
    assign unused_key_valid = key_valid;
    assign beat = key_ready;
`endif

    always_comb begin : p_chain
        logic [127:0] acc;
        acc = state_q;
        for (int j = 0; j < RPC; j++)
            acc = aes_round(acc, key_data[128*j +: 128], (int'(cnt) * RPC + j) == NR - 1);
        chain_out = acc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st        <= IDLE;
            cnt       <= '0;
            state_q   <= '0;
            out_data  <= '0;
            in_ready  <= 1'b1;
            key_ready <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (st)
                IDLE: if (in_valid) begin
                    state_q   <= in_data;
                    cnt       <= '0;
                    st        <= RUN;
                    in_ready  <= 1'b0;
                    key_ready <= 1'b1;
                end
                RUN: if (beat) begin
                    if (cnt == CW'(B - 1)) begin
                        out_data  <= chain_out ^ key_fin;
                        cnt       <= '0;
                        st        <= DONE;
                        key_ready <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        state_q <= chain_out;
                        cnt     <= cnt + CW'(1);
                    end
                end
                DONE: if (out_ready) begin
                    st        <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: begin
                    st        <= IDLE;
                    in_ready  <= 1'b1;
                    key_ready <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_aes_iter_core.sv
// tb/tb_aes_iter_core.sv - directed FIPS-197 vectors for aes_iter_core (NR=10/RPC=2 and NR=14/RPC=7).
module tb_aes_iter_core;
    localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] CT_C  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] KEY_A = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY_B = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY_C = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid, in_ready, key_valid, key_ready, out_valid, out_ready;
    logic [127:0] in_data, key_fin, out_data;
    logic [255:0] key_data;
    logic b_in_valid, b_in_ready, b_key_valid, b_key_ready, b_out_valid, b_out_ready;
    logic [127:0] b_in_data, b_key_fin, b_out_data;
    logic [895:0] b_key_data;

    int errors = 0;
    int checks = 0;
    logic [7:0] sbt [256];
    logic [0:14][127:0] rk_a, rk_b, rk_c;

    always #5 clk = ~clk;

    aes_iter_core #(.NR(10), .RPC(2)) u_dut (
        .clk(clk), .rst(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .key_valid(key_valid), .key_ready(key_ready), .key_data(key_data), .key_fin(key_fin),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    aes_iter_core #(.NR(14), .RPC(7)) u_dut256 (
        .clk(clk), .rst(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .key_valid(b_key_valid), .key_ready(b_key_ready), .key_data(b_key_data), .key_fin(b_key_fin),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00; x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from its algebraic definition: GF(2^8) inverse followed by the affine map.
    function automatic logic [7:0] sb_calc(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbt[w[31:24]], sbt[w[23:16]], sbt[w[15:8]], sbt[w[7:0]]};
    endfunction

    function automatic logic [0:14][127:0] expand(input logic [255:0] key, input int nk, input int nr);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0] rc;
        logic [0:14][127:0] rk;
        rc = 8'h01; rk = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk;
    endfunction

    task automatic run128(input logic [0:14][127:0] rk, input logic [127:0] pt, input logic hold_in,
                          input int stall_at, input int stall_len,
                          output int lat, output logic [127:0] ct);
        int beat;
        int cyc;
        in_valid = 1'b1; in_data = pt;
        @(posedge clk); #1;
        if (hold_in) in_data = ~pt;
        else in_valid = 1'b0;
        beat = 0; cyc = 0; key_fin = rk[10];
        while (!out_valid && cyc < 40) begin
            key_valid = !(cyc >= stall_at && cyc < stall_at + stall_len);
            key_data = (beat < 5) ? {rk[2*beat+1], rk[2*beat]} : '0;
            @(posedge clk); #1;
`ifdef AES_KEY_STALL_EN
            if (key_valid) beat++;
`else
            beat++;
`endif
            cyc++;
        end
        in_valid = 1'b0; key_valid = 1'b0;
        lat = cyc; ct = out_data;
    endtask

    task automatic drain128();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL drain: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL reset_key_ready: got %b expected 0", key_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 128'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        checks++; if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_dut256: in_ready=%b out_valid=%b expected 1/0", b_in_ready, b_out_valid);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_aes128();
        int lat;
        logic [127:0] ct;
        run128(rk_a, PT_A, 1'b0, 99, 0, lat, ct);
        checks++; if (lat !== 5) begin errors++; $display("FAIL aes128_latency: got %0d expected 5", lat); end
        checks++; if (ct !== CT_A) begin errors++; $display("FAIL aes128_data: got %h expected %h", ct, CT_A); end
        checks++; if (in_ready !== 1'b0 || key_ready !== 1'b0) begin
            errors++; $display("FAIL aes128_done_ready: in_ready=%b key_ready=%b expected 0/0", in_ready, key_ready);
        end
        drain128();
    endtask

    task automatic test_aes256();
        int cyc;
        b_in_valid = 1'b1; b_in_data = PT_A;
        @(posedge clk); #1;
        b_in_valid = 1'b0; b_key_valid = 1'b1; b_key_fin = rk_c[14]; cyc = 0;
        while (!b_out_valid && cyc < 20) begin
            for (int j = 0; j < 7; j++) b_key_data[128*j +: 128] = (cyc < 2) ? rk_c[7*cyc+j] : 128'h0;
            @(posedge clk); #1;
            cyc++;
        end
        b_key_valid = 1'b0;
        checks++; if (cyc !== 2) begin errors++; $display("FAIL aes256_latency: got %0d expected 2", cyc); end
        checks++; if (b_out_data !== CT_C) begin errors++; $display("FAIL aes256_data: got %h expected %h", b_out_data, CT_C); end
        b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_out_ready = 1'b0;
        checks++; if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin
            errors++; $display("FAIL aes256_drain: in_ready=%b out_valid=%b expected 1/0", b_in_ready, b_out_valid);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [127:0] ct;
        run128(rk_b, PT_B, 1'b0, 99, 0, lat, ct);
        checks++; if (ct !== CT_B) begin errors++; $display("FAIL bp_data: got %h expected %h", ct, CT_B); end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_data !== CT_B || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: data=%h valid=%b in_ready=%b expected %h/1/0", i, out_data, out_valid, in_ready, CT_B);
            end
        end
        drain128();
    endtask

    task automatic test_key_stall();
        int lat;
        logic [127:0] ct;
        int exp_lat;
`ifdef AES_KEY_STALL_EN
        exp_lat = 8;
`else
        exp_lat = 5;
`endif
        run128(rk_a, PT_A, 1'b0, 2, 3, lat, ct);
        checks++; if (lat !== exp_lat) begin errors++; $display("FAIL stall_latency: got %0d expected %0d", lat, exp_lat); end
        checks++; if (ct !== CT_A) begin errors++; $display("FAIL stall_data: got %h expected %h", ct, CT_A); end
        drain128();
    endtask

    task automatic test_reset_mid_run();
        int lat;
        logic [127:0] ct;
        in_valid = 1'b1; in_data = PT_B;
        @(posedge clk); #1;
        in_valid = 1'b0; key_valid = 1'b1; key_fin = rk_b[10];
        for (int b = 0; b < 2; b++) begin
            key_data = {rk_b[2*b+1], rk_b[2*b]};
            @(posedge clk); #1;
        end
        key_data = {rk_b[5], rk_b[4]};
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || key_ready !== 1'b0) begin
            errors++; $display("FAIL midrst_ready: in_ready=%b key_ready=%b expected 1/0", in_ready, key_ready);
        end
        checks++; if (out_valid !== 1'b0 || out_data !== 128'h0) begin
            errors++; $display("FAIL midrst_out: valid=%b data=%h expected 0/0", out_valid, out_data);
        end
        key_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        run128(rk_a, PT_A, 1'b0, 99, 0, lat, ct);
        checks++; if (lat !== 5) begin errors++; $display("FAIL midrst_latency: got %0d expected 5", lat); end
        checks++; if (ct !== CT_A) begin errors++; $display("FAIL midrst_data: got %h expected %h", ct, CT_A); end
        drain128();
    endtask

    task automatic test_ignore_in_valid();
        int lat;
        logic [127:0] ct;
        run128(rk_b, PT_B, 1'b1, 99, 0, lat, ct);
        checks++; if (ct !== CT_B) begin errors++; $display("FAIL ignore_in_data: got %h expected %h", ct, CT_B); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL ignore_in_latency: got %0d expected 5", lat); end
        drain128();
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [127:0] ct;
        out_ready = 1'b1;
        run128(rk_a, PT_A, 1'b0, 99, 0, lat, ct);
        checks++; if (ct !== CT_A) begin errors++; $display("FAIL b2b_first: got %h expected %h", ct, CT_A); end
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_turnaround: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
        run128(rk_b, PT_B, 1'b0, 99, 0, lat, ct);
        checks++; if (lat !== 5) begin errors++; $display("FAIL b2b_latency: got %0d expected 5", lat); end
        checks++; if (ct !== CT_B) begin errors++; $display("FAIL b2b_second: got %h expected %h", ct, CT_B); end
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle: in_ready=%b expected 1", in_ready); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = 1'b0; in_data = '0; key_valid = 1'b0; key_data = '0; key_fin = '0; out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_key_valid = 1'b0; b_key_data = '0; b_key_fin = '0; b_out_ready = 1'b0;
        for (int i = 0; i < 256; i++) sbt[i] = sb_calc(8'(i));
        rk_a = expand(KEY_A, 4, 10);
        rk_b = expand(KEY_B, 4, 10);
        rk_c = expand(KEY_C, 8, 14);
        test_reset();
        test_aes128();
        test_aes256();
        test_backpressure();
        test_key_stall();
        test_reset_mid_run();
        test_ignore_in_valid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
